// File: rtl/osc_seq_pkg.sv
// osc_seq_pkg: state encoding, synchroniser depth and counter widths shared
// by the oscillator clock/reset sequencer.
package osc_seq_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP     = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_RUN         = 3'd4,
        ST_FAULT       = 3'd5
    } state_e;

    localparam int SYNC_STAGES = 2;
    localparam int RELOCK_W    = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/osc_seq_sync2.sv
// osc_seq_sync2: multi-flop synchroniser for an asynchronous level input,
// cleared by an asynchronous active-high reset.
module osc_seq_sync2
    import osc_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff_q, ff_d;

    always_comb ff_d = {ff_q[SYNC_STAGES-2:0], d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= '0;
        else     ff_q <= ff_d;
    end

    assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/osc_clk_rst_sequencer.sv
// osc_clk_rst_sequencer: waits for oscillator settling, PLL lock and init-done,
// then releases staggered downstream resets; re-sequences on lock loss or request.
module osc_clk_rst_sequencer
    import osc_seq_pkg::*;
#(
    parameter int STARTUP_CYCLES     = 1024,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int LOCK_LOSS_FILTER   = 4,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_GAP          = 16,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PLL_LOCK,
    input  logic                  INIT_DONE,
    input  logic                  SW_RESET_REQ,
    output logic [NUM_STAGES-1:0] RST_OUT,
    output logic                  READY,
    output logic [2:0]            STATE,
    output logic                  LOCK_TIMEOUT,
    output logic [RELOCK_W-1:0]   RELOCK_COUNT
);

    localparam int CW = $clog2(max2(max2(STARTUP_CYCLES, LOCK_STABLE_CYCLES),
                                    max2(STAGE_GAP, TIMEOUT_CYCLES)) + 1);
    localparam int FW = $clog2(LOCK_LOSS_FILTER + 1);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-1:0]         flt_q, flt_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  timeout_q, timeout_d;
    logic [RELOCK_W-1:0]   relock_q, relock_d;
    logic                  lock_s, init_s, ok;

    osc_seq_sync2 u_sync_lock (.clk(CLK), .rst(RESET), .d(PLL_LOCK),  .q(lock_s));
    osc_seq_sync2 u_sync_init (.clk(CLK), .rst(RESET), .d(INIT_DONE), .q(init_s));

    assign ok = lock_s & init_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_STARTUP;
            cnt_q     <= '0;
            flt_q     <= '0;
            stage_q   <= '0;
            rst_out_q <= '1;
            timeout_q <= 1'b0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flt_q     <= flt_d;
            stage_q   <= stage_d;
            rst_out_q <= rst_out_d;
            timeout_q <= timeout_d;
            relock_q  <= relock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        flt_d     = '0;
        stage_d   = stage_q;
        timeout_d = timeout_q;
        relock_d  = relock_q;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (ok) begin
                    state_d = ST_LOCK_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_FAULT;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_FAULT: begin
                cnt_d   = '0;
                state_d = ok ? ST_LOCK_STABLE : ST_FAULT;
            end
            ST_LOCK_STABLE: begin
                if (!ok) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    cnt_d = '0;
                    if (stage_q == SW'(NUM_STAGES - 1)) state_d = ST_RUN;
                    else                                stage_d = stage_q + SW'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    flt_d = flt_q + FW'(1);
                    if (flt_q == FW'(LOCK_LOSS_FILTER - 1)) begin
                        state_d  = ST_WAIT_LOCK;
                        flt_d    = '0;
                        relock_d = (&relock_q) ? relock_q : relock_q + RELOCK_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_STARTUP;
                cnt_d   = '0;
            end
        endcase
        // A software request overrides any transition chosen above, including lock loss.
        if (SW_RESET_REQ) begin
            state_d   = ST_STARTUP;
            cnt_d     = '0;
            flt_d     = '0;
            stage_d   = '0;
            timeout_d = timeout_q;
            relock_d  = relock_q;
        end
    end

    // Reset outputs are registered from the next state so they never glitch.
    always_comb begin
        rst_out_d = '1;
        for (int i = 0; i < NUM_STAGES; i++)
            rst_out_d[i] = (state_d == ST_RUN) ? 1'b0 :
                           (state_d == ST_RELEASE && i <= int'(stage_d)) ? 1'b0 : 1'b1;
    end

    assign RST_OUT      = rst_out_q;
    assign READY        = (state_q == ST_RUN);
    assign STATE        = state_q;
    assign LOCK_TIMEOUT = timeout_q;
    assign RELOCK_COUNT = relock_q;

endmodule

// File: tb/tb_osc_clk_rst_sequencer.sv
// tb_osc_clk_rst_sequencer: directed cycle-exact checks of sequencing, timeout,
// lock-loss filtering, software re-sequence, async reset and counter saturation.
module tb_osc_clk_rst_sequencer;

    logic       CLK = 1'b0;
    logic       RESET, PLL_LOCK, INIT_DONE, SW_RESET_REQ;
    logic [2:0] RST_OUT;
    logic       READY;
    logic [2:0] STATE;
    logic       LOCK_TIMEOUT;
    logic [7:0] RELOCK_COUNT;

    int checks = 0;
    int errors = 0;

    osc_clk_rst_sequencer #(
        .STARTUP_CYCLES(8), .LOCK_STABLE_CYCLES(4), .LOCK_LOSS_FILTER(3),
        .NUM_STAGES(3), .STAGE_GAP(2), .TIMEOUT_CYCLES(32)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
        .SW_RESET_REQ(SW_RESET_REQ), .RST_OUT(RST_OUT), .READY(READY), .STATE(STATE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .RELOCK_COUNT(RELOCK_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (READY !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk("wait_ready", {7'd0, READY}, 8'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; PLL_LOCK = 1'b1; INIT_DONE = 1'b1; SW_RESET_REQ = 1'b0;
        step(3);
        chk("rst_state", {5'd0, STATE}, 8'd0);
        chk("rst_rstout", {5'd0, RST_OUT}, 8'd7);
        chk("rst_ready", {7'd0, READY}, 8'd0);
        chk("rst_timeout", {7'd0, LOCK_TIMEOUT}, 8'd0);
        chk("rst_relock", RELOCK_COUNT, 8'd0);
        RESET = 1'b0;
        // Nominal power-up, edges counted from the first edge after release
        step(7);  chk("t1_e7_state", {5'd0, STATE}, 8'd0);
        step(1);  chk("t1_e8_state", {5'd0, STATE}, 8'd1);
        step(1);  chk("t1_e9_state", {5'd0, STATE}, 8'd2);
        step(3);  chk("t1_e12_state", {5'd0, STATE}, 8'd2);
        chk("t1_e12_rst", {5'd0, RST_OUT}, 8'd7);
        step(1);  chk("t1_e13_state", {5'd0, STATE}, 8'd3);
        chk("t1_e13_rst", {5'd0, RST_OUT}, 8'd6);
        step(1);  chk("t1_e14_rst", {5'd0, RST_OUT}, 8'd6);
        step(1);  chk("t1_e15_rst", {5'd0, RST_OUT}, 8'd4);
        step(2);  chk("t1_e17_rst", {5'd0, RST_OUT}, 8'd0);
        chk("t1_e17_ready", {7'd0, READY}, 8'd0);
        step(1);  chk("t1_e18_ready", {7'd0, READY}, 8'd0);
        step(1);  chk("t1_e19_ready", {7'd0, READY}, 8'd1);
        chk("t1_e19_state", {5'd0, STATE}, 8'd4);
        // INIT_DONE is ignored once running
        INIT_DONE = 1'b0;
        step(10); chk("run_init_ignored", {7'd0, READY}, 8'd1);
        INIT_DONE = 1'b1;
        // Two-cycle lock glitch is filtered out
        PLL_LOCK = 1'b0; step(2);
        PLL_LOCK = 1'b1; step(4);
        chk("t3_glitch_ready", {7'd0, READY}, 8'd1);
        chk("t3_glitch_relock", RELOCK_COUNT, 8'd0);
        // Three-cycle lock loss trips the filter on the third low sample
        PLL_LOCK = 1'b0; step(3);
        PLL_LOCK = 1'b1; step(1);
        chk("t3_loss_pre_ready", {7'd0, READY}, 8'd1);
        step(1);
        chk("t3_loss_rst", {5'd0, RST_OUT}, 8'd7);
        chk("t3_loss_ready", {7'd0, READY}, 8'd0);
        chk("t3_loss_relock", RELOCK_COUNT, 8'd1);
        chk("t3_loss_state", {5'd0, STATE}, 8'd1);
        // Single low cycle in LOCK_STABLE restarts the full stable window
        step(1);  chk("t4_stable", {5'd0, STATE}, 8'd2);
        PLL_LOCK = 1'b0; step(1);
        PLL_LOCK = 1'b1; step(1);
        chk("t4_still_stable", {5'd0, STATE}, 8'd2);
        step(1);  chk("t4_back_wait", {5'd0, STATE}, 8'd1);
        step(1);  chk("t4_restable", {5'd0, STATE}, 8'd2);
        step(3);  chk("t4_window_not_done", {5'd0, STATE}, 8'd2);
        step(1);  chk("t4_release", {5'd0, STATE}, 8'd3);
        step(6);  chk("t4_run", {7'd0, READY}, 8'd1);
        // Software request coincident with filter expiry wins
        PLL_LOCK = 1'b0; step(3);
        PLL_LOCK = 1'b1; step(1);
        chk("t5_pre_ready", {7'd0, READY}, 8'd1);
        SW_RESET_REQ = 1'b1; step(1);
        SW_RESET_REQ = 1'b0;
        chk("t5_state", {5'd0, STATE}, 8'd0);
        chk("t5_rst", {5'd0, RST_OUT}, 8'd7);
        chk("t5_ready", {7'd0, READY}, 8'd0);
        chk("t5_relock", RELOCK_COUNT, 8'd1);
        // Lock never arrives: timeout after 32 WAIT_LOCK cycles
        PLL_LOCK = 1'b0;
        step(39); chk("t2_pre_state", {5'd0, STATE}, 8'd1);
        chk("t2_pre_timeout", {7'd0, LOCK_TIMEOUT}, 8'd0);
        step(1);  chk("t2_fault_state", {5'd0, STATE}, 8'd5);
        chk("t2_fault_timeout", {7'd0, LOCK_TIMEOUT}, 8'd1);
        chk("t2_fault_rst", {5'd0, RST_OUT}, 8'd7);
        PLL_LOCK = 1'b1;
        step(2);  chk("t2_fault_hold", {5'd0, STATE}, 8'd5);
        step(1);  chk("t2_fault_exit", {5'd0, STATE}, 8'd2);
        step(4);  chk("t2_release", {5'd0, STATE}, 8'd3);
        step(5);  chk("t2_pre_ready", {7'd0, READY}, 8'd0);
        step(1);  chk("t2_ready", {7'd0, READY}, 8'd1);
        chk("t2_timeout_sticky", {7'd0, LOCK_TIMEOUT}, 8'd1);
        // Asynchronous reset in the middle of RELEASE
        SW_RESET_REQ = 1'b1; step(1);
        SW_RESET_REQ = 1'b0;
        chk("t6_sw_state", {5'd0, STATE}, 8'd0);
        step(14);
        chk("t6_mid_release_state", {5'd0, STATE}, 8'd3);
        chk("t6_mid_release_rst", {5'd0, RST_OUT}, 8'd6);
        #3 RESET = 1'b1;
        #1;
        chk("t6_async_state", {5'd0, STATE}, 8'd0);
        chk("t6_async_rst", {5'd0, RST_OUT}, 8'd7);
        chk("t6_async_ready", {7'd0, READY}, 8'd0);
        chk("t6_async_timeout", {7'd0, LOCK_TIMEOUT}, 8'd0);
        chk("t6_async_relock", RELOCK_COUNT, 8'd1 - 8'd1);
        step(2);
        RESET = 1'b0;
        // 256 filtered lock losses: counter saturates at 255
        for (int i = 1; i <= 256; i++) begin
            wait_ready();
            PLL_LOCK = 1'b0; step(3);
            PLL_LOCK = 1'b1; step(2);
            if (i == 255) chk("sat_255", RELOCK_COUNT, 8'd255);
        end
        chk("sat_256", RELOCK_COUNT, 8'd255);
        chk("sat_state", {5'd0, STATE}, 8'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
